// File: rtl/led_matrix_pkg.sv
// Constants and helpers shared by the LED matrix column decoders and the column scanner.
package led_matrix_pkg;

    localparam int NUM_COLS  = 5;
    localparam int NUM_ROWS  = 7;
    localparam int COL_IDX_W = $clog2(NUM_COLS);

    typedef logic [NUM_ROWS-1:0] row_img_t;
    typedef logic [NUM_COLS-1:0] col_sel_t;

    localparam row_img_t ROWS_OFF = 7'h7F;
    localparam col_sel_t COLS_OFF = 5'b00000;

    function automatic col_sel_t col_onehot(input logic [COL_IDX_W-1:0] idx);
        col_sel_t sel;
        sel = COLS_OFF;
        for (int i = 0; i < NUM_COLS; i++) begin
            sel[i] = (idx == COL_IDX_W'(i));
        end
        return sel;
    endfunction

endpackage

// File: rtl/led_matrix_column_scanner_if.sv
// Row-image inputs and matrix pin outputs of the column scanner.
interface led_matrix_column_scanner_if;

    logic                                 enable;
    logic [led_matrix_pkg::NUM_ROWS-1:0]  col0_rows;
    logic [led_matrix_pkg::NUM_ROWS-1:0]  col1_rows;
    logic [led_matrix_pkg::NUM_ROWS-1:0]  col2_rows;
    logic [led_matrix_pkg::NUM_ROWS-1:0]  col3_rows;
    logic [led_matrix_pkg::NUM_ROWS-1:0]  col4_rows;
    logic [led_matrix_pkg::NUM_COLS-1:0]  column_select;
    logic [led_matrix_pkg::NUM_ROWS-1:0]  rows_n;
    logic                                 frame_start;

    modport master (
        output enable, col0_rows, col1_rows, col2_rows, col3_rows, col4_rows,
        input  column_select, rows_n, frame_start
    );

    modport slave (
        input  enable, col0_rows, col1_rows, col2_rows, col3_rows, col4_rows,
        output column_select, rows_n, frame_start
    );

endinterface

// File: rtl/led_matrix_column_scanner_scan_slot_counter.sv
// Slot divider and column index for the matrix scan; enable low parks both counters at zero.
module scan_slot_counter
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    output logic [CNT_W-1:0]     div_cnt_o,
    output logic [COL_IDX_W-1:0] col_idx_o,
    output logic                 wrap_o,
    output logic                 load_edge_o
);

    localparam logic [CNT_W-1:0]     DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [COL_IDX_W-1:0] COL_LAST = COL_IDX_W'(NUM_COLS - 1);

    logic [CNT_W-1:0]     div_cnt_q, div_cnt_d;
    logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;

    assign wrap_o      = (div_cnt_q == DIV_LAST);
    assign load_edge_o = enable_i && (div_cnt_q == '0) && (col_idx_q == '0);
    assign div_cnt_o   = div_cnt_q;
    assign col_idx_o   = col_idx_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        col_idx_d = col_idx_q;
        if (!enable_i) begin
            div_cnt_d = '0;
            col_idx_d = '0;
        end else if (wrap_o) begin
            div_cnt_d = '0;
            col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            col_idx_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            col_idx_q <= col_idx_d;
        end
    end

endmodule

// File: rtl/led_matrix_column_scanner.sv
// Time-multiplexed 5x7 LED matrix scanner with a per-frame image buffer.
// Define LED_SCAN_BLANK_EN to insert BLANK_CYCLES of dead time at the start of each column slot.
module led_matrix_column_scanner
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    led_matrix_column_scanner_if.slave  bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]     div_cnt;
    logic [COL_IDX_W-1:0] col_idx;
    logic                 slot_wrap;
    logic                 load_edge;

    row_img_t col_rows  [NUM_COLS];
    row_img_t frame_buf [NUM_COLS];

    col_sel_t column_select_q, column_select_d;
    row_img_t rows_n_q, rows_n_d;
    logic     frame_start_q, frame_start_d;

    scan_slot_counter #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_slot_counter (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (bus.enable),
        .div_cnt_o   (div_cnt),
        .col_idx_o   (col_idx),
        .wrap_o      (slot_wrap),
        .load_edge_o (load_edge)
    );

    assign col_rows[0] = bus.col0_rows;
    assign col_rows[1] = bus.col1_rows;
    assign col_rows[2] = bus.col2_rows;
    assign col_rows[3] = bus.col3_rows;
    assign col_rows[4] = bus.col4_rows;

    // One image register per column, refreshed only on the frame load edge.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_frame_buf
        row_img_t img_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                img_q <= '0;
            end else if (load_edge) begin
                img_q <= col_rows[gi];
            end
        end
        assign frame_buf[gi] = img_q;
    end

    always_comb begin
        column_select_d = COLS_OFF;
        rows_n_d        = ROWS_OFF;
        frame_start_d   = 1'b0;
        if (bus.enable) begin
            frame_start_d   = load_edge;
            column_select_d = col_onehot(col_idx);
            // The buffer is being written on this edge, so column 0 comes straight from the input.
            rows_n_d        = load_edge ? ~col_rows[0] : ~frame_buf[col_idx];
`ifdef LED_SCAN_BLANK_EN
            if (div_cnt < CNT_W'(BLANK_CYCLES)) begin
                column_select_d = COLS_OFF;
                rows_n_d        = ROWS_OFF;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            column_select_q <= COLS_OFF;
            rows_n_q        <= ROWS_OFF;
            frame_start_q   <= 1'b0;
        end else begin
            column_select_q <= column_select_d;
            rows_n_q        <= rows_n_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign bus.column_select = column_select_q;
    assign bus.rows_n        = rows_n_q;
    assign bus.frame_start   = frame_start_q;

    logic unused_wrap;
    assign unused_wrap = slot_wrap;

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Scoreboard bench for the LED matrix column scanner (SCAN_DIV=4, BLANK_CYCLES=1).
module tb_led_matrix_column_scanner;

    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 5 * SD;
`ifdef LED_SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    led_matrix_column_scanner_if scan_bus ();

    led_matrix_column_scanner #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (scan_bus.slave)
    );

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int m_t     = 0;
    logic [6:0]  m_buf [5];
    logic [12:0] exp_q [$];
    logic [4:0]  obs_col;
    logic [6:0]  obs_rows;
    logic        obs_fs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cols(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                            input logic [6:0] c3, input logic [6:0] c4);
        scan_bus.col0_rows = c0;
        scan_bus.col1_rows = c1;
        scan_bus.col2_rows = c2;
        scan_bus.col3_rows = c3;
        scan_bus.col4_rows = c4;
    endtask

    // Expected pins after this edge, from the count of enabled cycles since the scan restarted.
    task automatic model_edge();
        logic [12:0] e;
        int ph;
        int sl;
        if (reset || !scan_bus.enable) begin
            m_t = 0;
            e   = {5'b00000, 7'h7F, 1'b0};
        end else begin
            ph = m_t % SD;
            sl = (m_t / SD) % 5;
            if (m_t % FRAME == 0) begin
                m_buf[0] = scan_bus.col0_rows;
                m_buf[1] = scan_bus.col1_rows;
                m_buf[2] = scan_bus.col2_rows;
                m_buf[3] = scan_bus.col3_rows;
                m_buf[4] = scan_bus.col4_rows;
            end
            e = {5'(1 << sl), ~m_buf[sl], (m_t % FRAME == 0)};
            if (BLANK_ON && ph < BC) e[12:1] = {5'b00000, 7'h7F};
            m_t++;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        logic [12:0] e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        obs_col  = scan_bus.column_select;
        obs_rows = scan_bus.rows_n;
        obs_fs   = scan_bus.frame_start;
        $display("cyc %0d col=%b rows=%h fs=%b", cyc, obs_col, obs_rows, obs_fs);
        check_eq("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("sb_col", obs_col, e[12:8]);
            check_eq("sb_rows", obs_rows, e[7:1]);
            check_eq("sb_fs", obs_fs, e[0]);
        end
    endtask

    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        scan_bus.enable = 1'b0;
        set_cols(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        for (int i = 0; i < 5; i++) m_buf[i] = '0;

        // Reset before the first clock edge
        #1 reset = 1'b1;
        #1;
        check_eq("rst_col", scan_bus.column_select, 5'b00000);
        check_eq("rst_rows", scan_bus.rows_n, 7'h7F);
        check_eq("rst_fs", scan_bus.frame_start, 1'b0);
        tick();
        tick();

        // Basic scan and frame period
        set_cols(7'h01, 7'h02, 7'h04, 7'h08, 7'h10);
        scan_bus.enable = 1'b1;
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (cyc == 1) begin
                check_eq("c1_col", obs_col, BLANK_ON ? 5'b00000 : 5'b00001);
                check_eq("c1_rows", obs_rows, BLANK_ON ? 7'h7F : 7'h7E);
                check_eq("c1_fs", obs_fs, 1'b1);
            end
            if (cyc == 6) begin
                check_eq("c6_col", obs_col, 5'b00010);
                check_eq("c6_rows", obs_rows, 7'h7D);
            end
            if (cyc == 21) check_eq("c21_fs", obs_fs, 1'b1);
            if (cyc == 22) check_eq("c22_col", obs_col, 5'b00001);
        end

        // Input change mid-frame shows up only in the next frame
        restart();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cyc == 5) scan_bus.col3_rows = 7'h7F;
            if (cyc == 14) check_eq("hold_rows", obs_rows, 7'h77);
            if (cyc == 34) check_eq("next_rows", obs_rows, 7'h00);
        end

        // Enable dropped in the column-2 slot
        set_cols(7'h01, 7'h02, 7'h04, 7'h08, 7'h10);
        restart();
        for (int i = 0; i < 10; i++) tick();
        scan_bus.enable = 1'b0;
        tick();
        check_eq("dis_col", obs_col, 5'b00000);
        check_eq("dis_rows", obs_rows, 7'h7F);
        scan_bus.enable = 1'b1;
        tick();
        check_eq("reen_col", obs_col, BLANK_ON ? 5'b00000 : 5'b00001);
        check_eq("reen_fs", obs_fs, 1'b1);
        for (int i = 0; i < 6; i++) tick();

`ifdef LED_SCAN_BLANK_EN
        // Dead time at the start of each slot
        restart();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cyc == 1) check_eq("blk_fs", obs_fs, 1'b1);
            if (cyc == 5) check_eq("blk_col", obs_col, 5'b00000);
            if (cyc == 6) check_eq("blk_next", obs_col, 5'b00010);
        end
`endif

        // Asynchronous reset pulse in the column-4 slot
        restart();
        for (int i = 0; i < 18; i++) tick();
        check_eq("pre_col", obs_col, 5'b10000);
        scan_bus.col0_rows = 7'h55;
        #2 reset = 1'b1;
        #1;
        check_eq("arst_col", scan_bus.column_select, 5'b00000);
        check_eq("arst_rows", scan_bus.rows_n, 7'h7F);
        check_eq("arst_fs", scan_bus.frame_start, 1'b0);
        reset = 1'b0;
        m_t = 0;
        exp_q.delete();
        cyc = 0;
        tick();
        check_eq("rel_col", obs_col, BLANK_ON ? 5'b00000 : 5'b00001);
        check_eq("rel_rows", obs_rows, BLANK_ON ? 7'h7F : 7'h2A);
        check_eq("rel_fs", obs_fs, 1'b1);
        for (int i = 0; i < 6; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/led_matrix_column_scanner.md
# led_matrix_column_scanner

Time-multiplexed driver for the 5×7 LED matrix that shows irrigation status. It consumes the 7-bit row images produced by the five per-column status decoders and scans them onto the physical matrix one column at a time. It sits between the column decoders and the board pins. A frame buffer is captured once per frame so that a column image never changes part-way through a frame.

## Interface
- SCAN_DIV, 50000 — clock cycles per column slot; minimum 4 (1 kHz column rate at 50 MHz)
- BLANK_CYCLES, 2 — dead-time cycles at the start of each slot; requires 1 ≤ BLANK_CYCLES < SCAN_DIV; only used with LED_SCAN_BLANK_EN
- clk  in  1  system clock; rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  scan enable; low blanks the matrix and restarts the scan
- col0_rows … col4_rows  in  7 each  decoder row images; bit 0 = top row; 1 = LED on
- column_select  out  5  one-hot active-high column drive; bit k = column k
- rows_n  out  7  active-low row drive; bit 0 = top row
- frame_start  out  1  one-cycle pulse on the first output cycle of column 0

## Operation
- Internal state:
  - div_cnt, 0..SCAN_DIV-1, width $clog2(SCAN_DIV)
  - col_idx, 0..4
  - frame_buf, 5×7 bits
- Every cycle with enable=1, div_cnt increments. When it reaches SCAN_DIV-1 it wraps to 0 and col_idx advances; col_idx wraps 4→0.
- Load edge: any edge with enable=1, div_cnt==0 and col_idx==0. On it, frame_buf captures all five col*_rows inputs. This includes the first enabled edge after reset.
- Outputs are registered, computed from the pre-edge div_cnt and col_idx:
  - column_select = onehot(col_idx)
  - rows_n = ~frame_buf[col_idx]
  - On the load edge, rows_n bypasses the buffer and takes ~col0_rows directly, so no stale image is ever shown.
- frame_start is registered to 1 on the load edge and to 0 on every other edge.
- enable=0: next edge sets column_select=0, rows_n=7'h7F, frame_start=0, div_cnt=0 and col_idx=0; frame_buf holds its value. The next enabled edge is a load edge.
- Input changes between load edges are invisible until the next frame.

## Timing
- Reset (asserted, no clock needed): column_select=5'b00000, rows_n=7'h7F, frame_start=0, div_cnt=0, col_idx=0, frame_buf=0.
- Latency: 1 cycle from counter state to pins.
- First output cycle after reset release (enable=1): column_select=00001, rows_n=~col0_rows, frame_start=1.
- Slot length is SCAN_DIV cycles; frame length is 5·SCAN_DIV cycles; frame_start period is 5·SCAN_DIV.
- Reset asserted mid-frame: outputs blank immediately and the scan restarts at column 0 on release.
- Simultaneous reset and enable: reset wins.

## Configuration
- LED_SCAN_BLANK_EN defined: output cycles with pre-edge div_cnt < BLANK_CYCLES drive column_select=0 and rows_n=7'h7F (anti-ghosting dead time).
  - frame_start still pulses on the load edge, even though that cycle is blank.
- LED_SCAN_BLANK_EN undefined: no dead time; BLANK_CYCLES is ignored.

## Structure
- Shared package/include led_matrix_pkg holds NUM_COLS=5, NUM_ROWS=7, ROWS_OFF=7'h7F and COLS_OFF=5'b00000. The column decoders use the same constants.
- One sub-module: scan_slot_counter (div_cnt + col_idx, with outputs wrap and load_edge).
- Frame buffer, output registers and blanking logic stay in the top module.

## Test plan
All scenarios use SCAN_DIV=4 and BLANK_CYCLES=1.

1. Reset asserted with clock stopped -> column_select=00000, rows_n=7F, frame_start=0 immediately.
2. col0..col4 = 01,02,04,08,10 hex, enable=1, macro off, reset released:
   - cycle 1 -> column_select=00001, rows_n=7E, frame_start=1
   - cycle 5 -> column_select=00010, rows_n=7D
   - cycle 21 -> column_select=00001 with frame_start=1 (period 20)
3. col3_rows changed from 08 to 7F during the column-1 slot -> column-3 slot shows rows_n=77 in the current frame and rows_n=00 in the next frame.
4. enable dropped during the column-2 slot -> next cycle column_select=00000, rows_n=7F; re-enable -> first output cycle column_select=00001 with frame_start=1.
5. Macro on -> first cycle of every slot column_select=00000, rows_n=7F; remaining 3 cycles normal. Cycle 1 after reset is blank with frame_start=1.
6. Reset pulsed mid column-4 slot -> outputs blank asynchronously; after release the scan restarts at column 0 with a freshly captured buffer.
